// File: rtl/pe_mac_pipe_pkg.sv
// rtl/pe_mac_pipe_pkg.sv - shared mode type and default widths for the systolic PE array
package pe_mac_pipe_pkg;

    typedef enum logic [1:0] {
        PASSTHROUGH = 2'd0,
        LOAD        = 2'd1,
        PROCESS     = 2'd2
    } pe_mode_t;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

endpackage

// File: rtl/pe_mac_pipe_if.sv
// rtl/pe_mac_pipe_if.sv - PE signal bundle: control, west/north inputs, east/south outputs
interface pe_mac_pipe_if
    import pe_mac_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int WSEL_W = 2
);
    pe_mode_t          mode_i;
    logic [WSEL_W-1:0] wsel_i;
    logic              add_zero_i;
    logic [DATA_W-1:0] left_i;
    logic              left_valid_i;
    logic [DATA_W-1:0] right_o;
    logic              right_valid_o;
    logic [ACC_W-1:0]  top_i;
    logic              top_valid_i;
    logic [ACC_W-1:0]  bottom_o;
    logic              bottom_valid_o;
    logic              err_o;

    modport master (
        output mode_i, wsel_i, add_zero_i, left_i, left_valid_i, top_i, top_valid_i,
        input  right_o, right_valid_o, bottom_o, bottom_valid_o, err_o
    );

    modport slave (
        input  mode_i, wsel_i, add_zero_i, left_i, left_valid_i, top_i, top_valid_i,
        output right_o, right_valid_o, bottom_o, bottom_valid_o, err_o
    );
endinterface

// File: rtl/pe_weight_bank.sv
// rtl/pe_weight_bank.sv - stationary weight register file: sync write, combinational read,
// out-of-range index flag
module pe_weight_bank #(
    parameter int DATA_W      = 8,
    parameter int NUM_WEIGHTS = 4,
    parameter int WSEL_W      = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_we,
    input  logic [WSEL_W-1:0] i_sel,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_oor
);
    logic [DATA_W-1:0] r_mem [NUM_WEIGHTS];

    assign o_oor   = (32'(i_sel) >= 32'(NUM_WEIGHTS));
    assign o_rdata = o_oor ? '0 : r_mem[i_sel];

    // Out-of-range writes are dropped; the top reports them on err_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && !o_oor) begin
            r_mem[i_sel] <= i_wdata;
        end
    end
endmodule

// File: rtl/pe_mac_pipe.sv
// rtl/pe_mac_pipe.sv - weight-stationary systolic PE with 2-stage MAC; define PE_MAC_SAT_EN
// to saturate the south sum instead of wrapping
module pe_mac_pipe
    import pe_mac_pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int NUM_WEIGHTS = 4,
    parameter int WSEL_W      = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input logic          clk_i,
    input logic          rst_i,
    pe_mac_pipe_if.slave io
);
    generate
        if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
            $error("pe_mac_pipe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic [DATA_W-1:0]          w_weight;
    logic                       w_oor;
    logic                       w_load_we;
    logic                       w_fire;
    logic                       w_miss;
    logic                       w_idx_err;
    logic signed [2*DATA_W-1:0] w_prod_full;
    logic [ACC_W-1:0]           w_prod;
    logic [ACC_W-1:0]           w_addend;
    logic [ACC_W-1:0]           w_sum;

    logic [DATA_W-1:0] r_right;
    logic              r_right_v;
    logic [ACC_W-1:0]  r_s1_prod;
    logic [ACC_W-1:0]  r_s1_addend;
    logic              r_s1_v;
    logic [ACC_W-1:0]  r_s2_sum;
    logic              r_s2_v;
    logic              r_err;

    pe_weight_bank #(
        .DATA_W      (DATA_W),
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .WSEL_W      (WSEL_W)
    ) u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_load_we),
        .i_sel   (io.wsel_i),
        .i_wdata (io.top_i[DATA_W-1:0]),
        .o_rdata (w_weight),
        .o_oor   (w_oor)
    );

    always_comb begin
        w_load_we   = (io.mode_i == LOAD) && io.top_valid_i;
        w_fire      = (io.mode_i == PROCESS) && io.left_valid_i
                      && (io.top_valid_i || io.add_zero_i);
        w_miss      = (io.mode_i == PROCESS) && io.left_valid_i
                      && !io.top_valid_i && !io.add_zero_i;
        w_idx_err   = ((io.mode_i == LOAD) || (io.mode_i == PROCESS)) && w_oor;
        w_prod_full = $signed(w_weight) * $signed(io.left_i);
        w_prod      = w_oor ? '0 : ACC_W'(w_prod_full);
        w_addend    = io.add_zero_i ? '0 : io.top_i;
    end

`ifdef PE_MAC_SAT_EN
    logic [ACC_W:0] w_wide;

    // Guard bit disagreeing with the sign bit means the signed sum left the ACC_W range.
    always_comb begin
        w_wide = {r_s1_prod[ACC_W-1], r_s1_prod} + {r_s1_addend[ACC_W-1], r_s1_addend};
        if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
            w_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_sum = w_wide[ACC_W-1:0];
        end
    end
`else
    assign w_sum = r_s1_prod + r_s1_addend;
`endif

    // Passthrough reuses the S2 adder with a zero product so all modes share latency 2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_right     <= '0;
            r_right_v   <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_addend <= '0;
            r_s1_v      <= 1'b0;
            r_s2_sum    <= '0;
            r_s2_v      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_right   <= io.left_i;
            r_right_v <= io.left_valid_i;
            r_err     <= r_err | w_miss | w_idx_err;
            case (io.mode_i)
                PASSTHROUGH: begin
                    r_s1_prod   <= '0;
                    r_s1_addend <= io.top_i;
                    r_s1_v      <= io.top_valid_i;
                end
                PROCESS: begin
                    if (w_fire) begin
                        r_s1_prod   <= w_prod;
                        r_s1_addend <= w_addend;
                    end
                    r_s1_v <= w_fire;
                end
                default: r_s1_v <= 1'b0;
            endcase
            r_s2_sum <= w_sum;
            r_s2_v   <= r_s1_v;
        end
    end

    assign io.right_o        = r_right;
    assign io.right_valid_o  = r_right_v;
    assign io.bottom_o       = r_s2_sum;
    assign io.bottom_valid_o = r_s2_v;
    assign io.err_o          = r_err;
endmodule

// File: tb/tb_pe_mac_pipe.sv
// tb/tb_pe_mac_pipe.sv - scoreboard bench for pe_mac_pipe with an arithmetic reference model
module tb_pe_mac_pipe;
    import pe_mac_pipe_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 20;
    localparam int NW  = 4;
    localparam int NW3 = 3;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   rst3;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    longint m_wts [NW];
    bit     m_err;
    exp_t   bq[$];
    exp_t   rq[$];

    pe_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW), .WSEL_W(2)) bus ();
    pe_mac_pipe_if #(.DATA_W(DW), .ACC_W(AW), .WSEL_W(2)) bus3 ();

    pe_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .NUM_WEIGHTS(NW)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus.slave)
    );

    pe_mac_pipe #(.DATA_W(DW), .ACC_W(AW), .NUM_WEIGHTS(NW3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst3),
        .io    (bus3.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] acc_result(input longint s);
        longint hi = (longint'(1) << (AW - 1)) - 1;
        longint lo = -hi - 1;
        longint r  = s;
`ifdef PE_MAC_SAT_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        if (hi < lo) r = 0;
`endif
        return 32'(r & ((longint'(1) << AW) - 1));
    endfunction

    task automatic drive(input bit r, input pe_mode_t mode, input int wsel, input bit az,
                         input logic [7:0] left, input bit lv, input logic [19:0] top,
                         input bit tv);
        exp_t   e;
        exp_t   keep[$];
        bit     nerr;
        longint p;
        rst              = r;
        bus.mode_i       = mode;
        bus.wsel_i       = 2'(wsel);
        bus.add_zero_i   = az;
        bus.left_i       = left;
        bus.left_valid_i = lv;
        bus.top_i        = top;
        bus.top_valid_i  = tv;
        if (r) begin
            foreach (m_wts[i]) m_wts[i] = 0;
            keep = {};
            foreach (bq[i]) if (bq[i].due <= cyc) keep.push_back(bq[i]);
            bq = keep;
            keep = {};
            foreach (rq[i]) if (rq[i].due <= cyc) keep.push_back(rq[i]);
            rq = keep;
            nerr = 1'b0;
        end else begin
            nerr = m_err;
            if (lv) begin
                e.due = cyc + 1;
                e.val = 32'(left);
                rq.push_back(e);
            end
            if ((mode == LOAD || mode == PROCESS) && wsel >= NW) nerr = 1'b1;
            case (mode)
                PASSTHROUGH: if (tv) begin
                    e.due = cyc + 2;
                    e.val = 32'(top);
                    bq.push_back(e);
                end
                LOAD: if (tv && wsel < NW) m_wts[wsel] = longint'($signed(top[7:0]));
                PROCESS: begin
                    if (lv && !tv && !az) begin
                        nerr = 1'b1;
                    end else if (lv) begin
                        p = (wsel < NW) ? m_wts[wsel] * longint'($signed(left)) : 0;
                        e.due = cyc + 2;
                        e.val = acc_result(p + (az ? 0 : longint'($signed(top))));
                        bq.push_back(e);
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        m_err = nerr;
    endtask

    task automatic idle();
        drive(1'b0, PASSTHROUGH, 0, 1'b0, 8'h00, 1'b0, 20'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        bit ev;
        ev = (bq.size() > 0) && (bq[0].due == cyc);
        check("bottom_valid", 32'(bus.bottom_valid_o), 32'(ev));
        if (ev) begin
            check("bottom_data", 32'(bus.bottom_o), bq[0].val);
            void'(bq.pop_front());
        end
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        check("right_valid", 32'(bus.right_valid_o), 32'(ev));
        if (ev) begin
            check("right_data", 32'(bus.right_o), rq[0].val);
            void'(rq.pop_front());
        end
        check("err", 32'(bus.err_o), 32'(m_err));
    end

    initial begin
        int mode_r;
        int wsel_r;
        bit az_r;
        bit lv_r;
        bit tv_r;
        rst  = 1'b1;
        rst3 = 1'b1;
        m_err = 1'b0;
        bus.mode_i  = PASSTHROUGH; bus.wsel_i  = '0; bus.add_zero_i  = 1'b0;
        bus.left_i  = '0; bus.left_valid_i  = 1'b0; bus.top_i  = '0; bus.top_valid_i  = 1'b0;
        bus3.mode_i = PASSTHROUGH; bus3.wsel_i = '0; bus3.add_zero_i = 1'b0;
        bus3.left_i = '0; bus3.left_valid_i = 1'b0; bus3.top_i = '0; bus3.top_valid_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset: live traffic, then reset with garbage inputs discards it
        drive(1'b0, PASSTHROUGH, 0, 1'b0, 8'h33, 1'b1, 20'h55555, 1'b1);
        drive(1'b1, PROCESS, 3, 1'b0, 8'hA5, 1'b1, 20'hABCDE, 1'b1);
        @(negedge clk);
        check("rst_right_o", 32'(bus.right_o), 32'h0);
        check("rst_right_valid", 32'(bus.right_valid_o), 32'h0);
        check("rst_bottom_o", 32'(bus.bottom_o), 32'h0);
        check("rst_bottom_valid", 32'(bus.bottom_valid_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);
        drive(1'b0, PROCESS, 0, 1'b0, 8'd7, 1'b1, 20'd50, 1'b1);

        // Basic MAC, add_zero, mode switch, overflow
        drive(1'b0, LOAD, 2, 1'b0, 8'h00, 1'b0, 20'h000FD, 1'b1);
        drive(1'b0, PROCESS, 2, 1'b0, 8'd5, 1'b1, 20'd100, 1'b1);
        drive(1'b0, LOAD, 1, 1'b0, 8'h00, 1'b0, 20'h00080, 1'b1);
        drive(1'b0, PROCESS, 1, 1'b1, 8'h80, 1'b1, 20'h12345, 1'b0);
        drive(1'b0, PROCESS, 2, 1'b0, 8'd2, 1'b1, 20'd10, 1'b1);
        drive(1'b0, PASSTHROUGH, 0, 1'b0, 8'h00, 1'b0, 20'h12345, 1'b1);
        drive(1'b0, LOAD, 3, 1'b0, 8'h00, 1'b0, 20'd127, 1'b1);
        drive(1'b0, PROCESS, 3, 1'b0, 8'd127, 1'b1, 20'h7FFFF, 1'b1);
        drive(1'b0, LOAD, 0, 1'b0, 8'h00, 1'b0, 20'h00081, 1'b1);
        drive(1'b0, PROCESS, 0, 1'b0, 8'd127, 1'b1, 20'h80000, 1'b1);
        repeat (3) idle();

        // Randomized traffic without error-raising combinations, one mid-run reset
        for (int i = 0; i < 400; i++) begin
            mode_r = $urandom_range(0, 3);
            wsel_r = $urandom_range(0, NW - 1);
            az_r   = 1'($urandom_range(0, 3) == 0);
            lv_r   = 1'($urandom_range(0, 3) != 0);
            tv_r   = 1'($urandom_range(0, 3) != 0);
            if (mode_r >= 2 && lv_r && !tv_r) az_r = 1'b1;
            drive(i == 200, (mode_r >= 2) ? PROCESS : pe_mode_t'(mode_r), wsel_r, az_r,
                  8'($urandom), lv_r, 20'($urandom), tv_r);
        end
        repeat (3) idle();

        // Missing partial sum: no output, sticky error, cleared only by reset
        drive(1'b0, PROCESS, 0, 1'b0, 8'd9, 1'b1, 20'd1, 1'b0);
        repeat (3) idle();
        drive(1'b1, PASSTHROUGH, 0, 1'b0, 8'h00, 1'b0, 20'h0, 1'b0);
        repeat (2) @(posedge clk);

        // Out-of-range index on a 3-entry bank
        #1;
        rst3 = 1'b0;
        bus3.mode_i = LOAD; bus3.wsel_i = 2'd3; bus3.top_i = 20'd5; bus3.top_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus3.mode_i = PASSTHROUGH; bus3.top_valid_i = 1'b0;
        @(negedge clk);
        check("idx_load_err", 32'(bus3.err_o), 32'h1);
        bus3.mode_i = PROCESS; bus3.wsel_i = 2'd3; bus3.left_i = 8'd4;
        bus3.left_valid_i = 1'b1; bus3.top_i = 20'd9; bus3.top_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus3.mode_i = PASSTHROUGH; bus3.left_valid_i = 1'b0; bus3.top_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idx_proc_valid", 32'(bus3.bottom_valid_o), 32'h1);
        check("idx_proc_sum", 32'(bus3.bottom_o), 32'd9);
        check("idx_err_sticky", 32'(bus3.err_o), 32'h1);
        rst3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idx_err_cleared", 32'(bus3.err_o), 32'h0);

        check("drain_bottom", 32'(bq.size()), 32'h0);
        check("drain_right", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
